stage_memory: RTL and testbench
===============================

Name: stage_memory

Overview:
Memory stage of the 5-stage RV32 pipeline. Sits between stage_execute and writeback.
- Performs loads and stores over a single-outstanding req/ack data bus.
- Resolves branches and jumps into a redirect.
- Flags misaligned accesses.
- Registers the writeback bundle for the register file.
- Stalls execute via mem_stall while a bus access is pending.

Parameters:
None. Datapath is fixed at 32-bit RV32. Width codes and FSM encodings come from defines.vh.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
mem_valid  in  1  instruction present; upstream holds all mem_* inputs stable while mem_stall=1
mem_pc  in  32  instruction PC
mem_data0  in  32  ALU result: load/store address, branch compare result (bit0), or jump link value
mem_data1  in  32  store data, or branch/jump target
mem_read  in  1  load
mem_write  in  1  store
mem_extend  in  1  1 = sign-extend load result, 0 = zero-extend
mem_width  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
mem_jmp  in  1  unconditional jump
mem_br  in  1  conditional branch
mem_br_inv  in  1  invert branch condition
wb_reg  in  5  destination register; 0 = none
mem_stall  out  1  hold upstream
mem_forward_data  out  32  forwarding value (mem_data0)
mem_wen  out  1  forwarding valid
br_taken  out  1  redirect request
br_target  out  32  redirect PC, bit0 forced 0
dbus_req  out  1  bus request, registered
dbus_we  out  1  write, registered
dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00}), registered
dbus_wdata  out  32  lane-replicated store data, registered
dbus_be  out  4  byte enables, registered
dbus_ack  in  1  bus completion; valid only while dbus_req=1
dbus_rdata  in  32  read data, valid with dbus_ack
wb_valid  out  1  writeback bundle valid
wb_wen  out  1  write register file
wb_reg_r  out  5  writeback register
wb_data  out  32  writeback data
exc_valid  out  1  misaligned or illegal-width exception, one-cycle pulse
exc_pc  out  32  faulting PC
exc_addr  out  32  faulting address

Behaviour:
- Reset: state=IDLE. wb_valid, wb_wen, exc_valid, dbus_req, dbus_we = 0. dbus_be = 0. wb_reg_r = 0. Data registers = 0.
- Reset mid-access: FSM returns to IDLE and dbus_req drops the next edge. Any late ack is ignored.
- Definitions:
  - memop = mem_valid & (mem_read | mem_write).
  - mis = (width==1 & a[0]) | (width==2 & a[1:0]!=0) | width==3, where a = mem_data0.
- FSM states: IDLE, REQ, DONE.
  - IDLE, memop & ~mis: register dbus_req=1, addr, we, be, wdata; go to REQ. mem_stall=1.
  - IDLE, memop & mis: no request issued. exc_valid pulses next cycle with exc_pc=mem_pc and exc_addr=a. The instruction retires with wb_valid=1, wb_wen=0. mem_stall=0.
  - REQ: mem_stall=1, dbus_req held high. On dbus_ack, capture aligned load data, drop req, go to DONE. With no ack, remain in REQ indefinitely.
  - DONE: mem_stall=0. The instruction retires this cycle, then the FSM returns to IDLE.
  - Minimum memory-op occupancy is 3 cycles (ack in the first REQ cycle).
- Non-memory instructions complete in IDLE with mem_stall=0, i.e. 1 cycle.
- Store lanes:
  - byte: be = 4'b0001<<a[1:0], wdata = {4{d1[7:0]}}.
  - half: be = 4'b0011<<{a[1],1'b0}, wdata = {2{d1[15:0]}}.
  - word: be = 4'b1111, wdata = d1.
- Load extract: select byte a[1:0] or half a[1] from dbus_rdata, then sign- or zero-extend per mem_extend.
- Branch resolution:
  - br_taken = mem_valid & ~mem_stall & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv))).
  - br_target = {mem_data1[31:1],1'b0}.
  - Both are combinational.
- Forwarding: mem_forward_data = mem_data0. mem_wen = mem_valid & ~mem_read & ~mem_write & wb_reg!=0. Load forwarding is not provided; the hazard unit stalls loads.
- Writeback (registered, on every non-stalled edge):
  - wb_valid <= mem_valid & ~mem_stall.
  - wb_wen <= that & wb_reg!=0 & ~mem_write & ~mem_br & ~mis.
  - wb_data <= mem_read ? load result : mem_data0.
  - wb_reg_r <= wb_reg.
- While mem_stall=1: wb_valid=0 and no redirect is issued.
- mem_read and mem_write together is not legal input; mem_write takes precedence.

Decomposition:
- Shared package, defines.vh:
  - MEMW_BYTE/HALF/WORD width codes.
  - MS_IDLE/MS_REQ/MS_DONE state encodings.
- Sub-module mem_align (combinational):
  - Store path: (addr[1:0], width, data) -> be, wdata.
  - Load path: (addr[1:0], width, extend, rdata) -> result.
  - Misalign flag.

Test Plan:
- Load byte, signed. addr 0x1003, extend=1, rdata 0x80FFFFFF, ack in first REQ cycle -> mem_stall high 2 cycles, wb_data=0xFFFFFF80, wb_wen=1.
- Store half. addr 0x2002, d1=0x0000BEEF -> dbus_be=4'b1100, dbus_wdata=0xBEEFBEEF, dbus_addr=0x2000, wb_wen=0.
- Ack delayed 5 cycles on a word load, 0x12345678 -> stall held 6 cycles, dbus_req stays high throughout, wb_data=0x12345678 exactly once.
- Misaligned word load at 0x1001 -> no dbus_req, exc_valid pulse with exc_addr=0x1001, mem_stall=0, wb_wen=0.
- Branch: mem_br=1, data0=0, br_inv=1, data1=0x401 -> br_taken=1, br_target=0x400. Same case with br_inv=0 -> br_taken=0.
- reset_n low while in REQ -> next edge state IDLE, dbus_req=0; an ack after reset causes no writeback.

Source files
------------

// File: rtl/stage_memory_pkg.sv
// Shared encodings for the memory stage: access width codes and FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package stage_memory_pkg;

    localparam logic [1:0] MEMW_BYTE = 2'd0;
    localparam logic [1:0] MEMW_HALF = 2'd1;
    localparam logic [1:0] MEMW_WORD = 2'd2;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/stage_memory_mem_align.sv
// Lane steering for stores, lane extraction/extension for loads, misalign detection.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module mem_align
    import stage_memory_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  width,
    input  logic        extend,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        mis
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: byte enables, replicated write data and the misalign flag.
    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        mis   = 1'b0;
        case (width)
            MEMW_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MEMW_HALF: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
                mis   = addr_lo[0];
            end
            MEMW_WORD: begin
                be    = 4'b1111;
                mis   = (addr_lo != 2'b00);
            end
            default: begin
                // width code 3 is illegal and always faults
                be    = 4'b0000;
                mis   = 1'b1;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend it.
    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (width)
            MEMW_BYTE: load_data = {{24{extend & byte_sel[7]}}, byte_sel};
            MEMW_HALF: load_data = {{16{extend & half_sel[15]}}, half_sel};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory stage: single-outstanding data bus access, branch redirect, misalign trap, writeback register.
// Latency: non-memory ops 1 cycle; memory ops >= 3 cycles (issue, REQ until ack, DONE).
// Backpressure: mem_stall holds upstream from issue until ack; dbus_req is held until dbus_ack.
module stage_memory
    import stage_memory_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_data0,
    input  logic [31:0] mem_data1,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_extend,
    input  logic [1:0]  mem_width,
    input  logic        mem_jmp,
    input  logic        mem_br,
    input  logic        mem_br_inv,
    input  logic [4:0]  wb_reg,
    output logic        mem_stall,
    output logic [31:0] mem_forward_data,
    output logic        mem_wen,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        wb_valid,
    output logic        wb_wen,
    output logic [4:0]  wb_reg_r,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [31:0] exc_pc,
    output logic [31:0] exc_addr
);

    mem_state_t  state;
    mem_state_t  state_next;
    logic        memop;
    logic        mis;
    logic        issue;
    logic        fault;
    logic        ack_take;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic [31:0] load_q;

    mem_align u_align (
        .addr_lo    (mem_data0[1:0]),
        .width      (mem_width),
        .extend     (mem_extend),
        .store_data (mem_data1),
        .rdata      (dbus_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .mis        (mis)
    );

    assign memop    = mem_valid & (mem_read | mem_write);
    assign issue    = (state == MS_IDLE) & memop & ~mis;
    assign fault    = (state == MS_IDLE) & memop & mis;
    // acks outside REQ (e.g. after a reset mid-access) are ignored
    assign ack_take = (state == MS_REQ) & dbus_ack;

    assign mem_forward_data = mem_data0;
    assign mem_wen          = mem_valid & ~mem_read & ~mem_write & (wb_reg != 5'd0);
    assign br_taken         = mem_valid & ~mem_stall
                            & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
    assign br_target        = {mem_data1[31:1], 1'b0};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= MS_IDLE;
        else          state <= state_next;
    end

    // FSM next state and stall output.
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            MS_IDLE: begin
                if (issue) begin
                    state_next = MS_REQ;
                    mem_stall  = 1'b1;
                end
            end
            MS_REQ: begin
                mem_stall = 1'b1;
                if (dbus_ack) state_next = MS_DONE;
            end
            MS_DONE: state_next = MS_IDLE;
            default: state_next = MS_IDLE;
        endcase
    end

    // Bus request registers: launched on issue, held until ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'd0;
            dbus_wdata <= 32'd0;
            dbus_be    <= 4'b0000;
            load_q     <= 32'd0;
        end else if (issue) begin
            dbus_req   <= 1'b1;
            dbus_we    <= mem_write;
            dbus_addr  <= {mem_data0[31:2], 2'b00};
            dbus_wdata <= al_wdata;
            dbus_be    <= al_be;
        end else if (ack_take) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            load_q     <= al_load;
        end
    end

    // Writeback bundle: retires on every non-stalled cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            wb_reg_r <= 5'd0;
            wb_data  <= 32'd0;
        end else if (mem_stall) begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
        end else begin
            wb_valid <= mem_valid;
            wb_wen   <= mem_valid & (wb_reg != 5'd0) & ~mem_write & ~mem_br & ~(memop & mis);
            wb_data  <= (mem_read & ~mem_write) ? load_q : mem_data0;
            wb_reg_r <= wb_reg;
        end
    end

    // Exception pulse for misaligned or illegal-width accesses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exc_valid <= 1'b0;
            exc_pc    <= 32'd0;
            exc_addr  <= 32'd0;
        end else begin
            exc_valid <= fault;
            if (fault) begin
                exc_pc   <= mem_pc;
                exc_addr <= mem_data0;
            end
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: loads, stores, delayed ack, misalign, branches, reset mid-access.
// Latency: n/a.
// Backpressure: bus responder acks after a programmable number of REQ cycles.
module tb_stage_memory;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic [31:0] mem_pc, mem_data0, mem_data1;
    logic        mem_read, mem_write, mem_extend;
    logic [1:0]  mem_width;
    logic        mem_jmp, mem_br, mem_br_inv;
    logic [4:0]  wb_reg;
    logic        mem_stall;
    logic [31:0] mem_forward_data;
    logic        mem_wen;
    logic        br_taken;
    logic [31:0] br_target;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        wb_valid, wb_wen;
    logic [4:0]  wb_reg_r;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [31:0] exc_pc, exc_addr;

    int checks = 0;
    int errors = 0;

    stage_memory dut (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_data0(mem_data0), .mem_data1(mem_data1), .mem_read(mem_read),
        .mem_write(mem_write), .mem_extend(mem_extend), .mem_width(mem_width),
        .mem_jmp(mem_jmp), .mem_br(mem_br), .mem_br_inv(mem_br_inv), .wb_reg(wb_reg),
        .mem_stall(mem_stall), .mem_forward_data(mem_forward_data), .mem_wen(mem_wen),
        .br_taken(br_taken), .br_target(br_target), .dbus_req(dbus_req),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_be(dbus_be), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_reg_r(wb_reg_r), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 0; mem_pc = 0; mem_data0 = 0; mem_data1 = 0;
        mem_read = 0; mem_write = 0; mem_extend = 0; mem_width = 2'd2;
        mem_jmp = 0; mem_br = 0; mem_br_inv = 0; wb_reg = 0;
        dbus_ack = 0; dbus_rdata = 0;
    endtask

    // Bus responder: acks in REQ cycle number delay+1; returns stall cycles and req drop-outs.
    task automatic bus_cycle(input int delay, input logic [31:0] rd,
                             output int stalls, output int req_gaps);
        int req_seen;
        stalls = 0; req_gaps = 0; req_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (!mem_stall) break;
            stalls++;
            if (c > 0 && !dbus_req) req_gaps++;
            if (dbus_req) req_seen++;
            dbus_ack   = dbus_req && (req_seen == delay + 1);
            dbus_rdata = rd;
            step();
            dbus_ack = 0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        step(); step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        checks++; if (dbus_req !== 1'b0 || dbus_we !== 1'b0) begin errors++; $display("FAIL reset_dbus got req=%b we=%b want 0", dbus_req, dbus_we); end
        checks++; if (dbus_be !== 4'b0000) begin errors++; $display("FAIL reset_be got %b want 0000", dbus_be); end
        checks++; if (exc_valid !== 1'b0 || wb_wen !== 1'b0) begin errors++; $display("FAIL reset_flags got exc=%b wen=%b want 0", exc_valid, wb_wen); end
        checks++; if (wb_reg_r !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb got reg=%0d data=%h want 0", wb_reg_r, wb_data); end
        reset_n = 1;
        step();
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", mem_stall); end
    endtask

    task automatic test_load_byte_signed();
        int stalls, gaps;
        mem_valid = 1; mem_pc = 32'h100; mem_data0 = 32'h1003; mem_read = 1;
        mem_extend = 1; mem_width = 2'd0; wb_reg = 5;
        #1;
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL lb_no_redirect got %b want 0", br_taken); end
        bus_cycle(0, 32'h80FF_FFFF, stalls, gaps);
        checks++; if (stalls !== 2) begin errors++; $display("FAIL lb_stall_cycles got %0d want 2", stalls); end
        checks++; if (dbus_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr got %h want 00001000", dbus_addr); end
        step();
        mem_valid = 0; mem_read = 0;
        checks++; if (wb_valid !== 1'b1 || wb_wen !== 1'b1) begin errors++; $display("FAIL lb_wb got valid=%b wen=%b want 1 1", wb_valid, wb_wen); end
        checks++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", wb_data); end
        checks++; if (wb_reg_r !== 5'd5) begin errors++; $display("FAIL lb_reg got %0d want 5", wb_reg_r); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lb_single_retire got %b want 0", wb_valid); end
    endtask

    task automatic test_load_half_unsigned();
        int stalls, gaps;
        mem_valid = 1; mem_data0 = 32'h1002; mem_read = 1; mem_extend = 0;
        mem_width = 2'd1; wb_reg = 6;
        #1;
        bus_cycle(0, 32'h8001_1234, stalls, gaps);
        step();
        mem_valid = 0; mem_read = 0;
        checks++; if (wb_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data got %h want 00008001", wb_data); end
        step();
    endtask

    task automatic test_store_half();
        int stalls, gaps;
        mem_valid = 1; mem_data0 = 32'h2002; mem_data1 = 32'h0000_BEEF; mem_write = 1;
        mem_width = 2'd1; wb_reg = 7;
        #1;
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL sh_fwd_wen got %b want 0", mem_wen); end
        step();
        checks++; if (dbus_req !== 1'b1 || dbus_we !== 1'b1) begin errors++; $display("FAIL sh_req got req=%b we=%b want 1 1", dbus_req, dbus_we); end
        checks++; if (dbus_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", dbus_be); end
        checks++; if (dbus_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h want beefbeef", dbus_wdata); end
        checks++; if (dbus_addr !== 32'h2000) begin errors++; $display("FAIL sh_addr got %h want 00002000", dbus_addr); end
        bus_cycle(0, 32'h0, stalls, gaps);
        step();
        mem_valid = 0; mem_write = 0;
        checks++; if (wb_valid !== 1'b1 || wb_wen !== 1'b0) begin errors++; $display("FAIL sh_wb got valid=%b wen=%b want 1 0", wb_valid, wb_wen); end
        step();
    endtask

    task automatic test_store_byte();
        mem_valid = 1; mem_data0 = 32'h2001; mem_data1 = 32'h0000_00A5; mem_write = 1;
        mem_width = 2'd0; wb_reg = 0;
        #1;
        step();
        checks++; if (dbus_be !== 4'b0010 || dbus_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_lanes got be=%b wdata=%h want 0010 a5a5a5a5", dbus_be, dbus_wdata); end
        dbus_ack = 1;
        step();
        dbus_ack = 0;
        step();
        mem_valid = 0; mem_write = 0;
        step();
    endtask

    task automatic test_delayed_ack();
        int stalls, gaps, retires;
        mem_valid = 1; mem_data0 = 32'h3000; mem_read = 1; mem_width = 2'd2; wb_reg = 8;
        #1;
        bus_cycle(4, 32'h1234_5678, stalls, gaps);
        checks++; if (stalls !== 6) begin errors++; $display("FAIL slow_stall_cycles got %0d want 6", stalls); end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL slow_req_held got %0d drops want 0", gaps); end
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL slow_req_drop got %b want 0", dbus_req); end
        retires = 0;
        step();
        mem_valid = 0; mem_read = 0;
        if (wb_valid) retires++;
        checks++; if (wb_data !== 32'h1234_5678) begin errors++; $display("FAIL slow_data got %h want 12345678", wb_data); end
        step(); if (wb_valid) retires++;
        step(); if (wb_valid) retires++;
        checks++; if (retires !== 1) begin errors++; $display("FAIL slow_retire_count got %0d want 1", retires); end
    endtask

    task automatic test_misaligned();
        mem_valid = 1; mem_pc = 32'h500; mem_data0 = 32'h1001; mem_read = 1;
        mem_width = 2'd2; wb_reg = 3;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %b want 0", mem_stall); end
        step();
        mem_valid = 0; mem_read = 0;
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL mis_no_req got %b want 0", dbus_req); end
        checks++; if (exc_valid !== 1'b1 || exc_addr !== 32'h1001 || exc_pc !== 32'h500) begin errors++; $display("FAIL mis_exc got v=%b addr=%h pc=%h want 1 00001001 00000500", exc_valid, exc_addr, exc_pc); end
        checks++; if (wb_valid !== 1'b1 || wb_wen !== 1'b0) begin errors++; $display("FAIL mis_wb got valid=%b wen=%b want 1 0", wb_valid, wb_wen); end
        step();
        checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b want 0", exc_valid); end
    endtask

    task automatic test_branch();
        mem_valid = 1; mem_br = 1; mem_data0 = 32'h0; mem_br_inv = 1; mem_data1 = 32'h401; wb_reg = 0;
        #1;
        checks++; if (br_taken !== 1'b1 || br_target !== 32'h400) begin errors++; $display("FAIL br_inv_taken got %b %h want 1 00000400", br_taken, br_target); end
        mem_br_inv = 0;
        #1;
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_not_taken got %b want 0", br_taken); end
        mem_br = 0; mem_jmp = 1; mem_data0 = 32'h0000_0104; wb_reg = 1;
        #1;
        checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL jmp_taken got %b want 1", br_taken); end
        step();
        mem_jmp = 0; mem_valid = 0;
        checks++; if (wb_wen !== 1'b1 || wb_data !== 32'h104) begin errors++; $display("FAIL jmp_link got wen=%b data=%h want 1 00000104", wb_wen, wb_data); end
    endtask

    task automatic test_alu_forward();
        mem_valid = 1; mem_data0 = 32'hCAFE_F00D; wb_reg = 9;
        #1;
        checks++; if (mem_wen !== 1'b1 || mem_forward_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL alu_fwd got wen=%b data=%h want 1 cafef00d", mem_wen, mem_forward_data); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_reg_r !== 5'd9) begin errors++; $display("FAIL alu_wb got v=%b wen=%b reg=%0d want 1 1 9", wb_valid, wb_wen, wb_reg_r); end
        wb_reg = 0;
        #1;
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL alu_x0_fwd got %b want 0", mem_wen); end
        step();
        mem_valid = 0;
        checks++; if (wb_valid !== 1'b1 || wb_wen !== 1'b0) begin errors++; $display("FAIL alu_x0_wb got v=%b wen=%b want 1 0", wb_valid, wb_wen); end
        step();
    endtask

    task automatic test_reset_mid_access();
        mem_valid = 1; mem_data0 = 32'h4000; mem_read = 1; mem_width = 2'd2; wb_reg = 4;
        #1;
        step();
        checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_up got %b want 1", dbus_req); end
        reset_n = 0; mem_valid = 0; mem_read = 0;
        step();
        checks++; if (dbus_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got req=%b stall=%b want 0 0", dbus_req, mem_stall); end
        reset_n = 1; dbus_ack = 1; dbus_rdata = 32'hDEAD_BEEF;
        step();
        dbus_ack = 0;
        checks++; if (wb_valid !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL rst_late_ack got wb=%b req=%b want 0 0", wb_valid, dbus_req); end
        step();
        checks++; if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rst_late_ack2 got wb=%b stall=%b want 0 0", wb_valid, mem_stall); end
    endtask

    initial begin
        test_reset();
        test_load_byte_signed();
        test_load_half_unsigned();
        test_store_half();
        test_store_byte();
        test_delayed_ack();
        test_misaligned();
        test_branch();
        test_alu_forward();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
